// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//
// Pipeline sequencing controller for the five-stage RISC-V core. It turns the
// decoded Mem control field and the register indices into stage write-enables,
// bubble and flush strobes. It freezes the whole pipeline while a multi-cycle
// data-memory access completes.
//
// Optional feature macro: HAZARD_PERF_CNT_EN
//   defined   -> saturating stall-cycle and flush counters on stall_cnt_o and
//                flush_cnt_o
//   undefined -> both counter ports tied to 0, no counter registers
//
// Ports
//   clk_i              clock, rising edge
//   rst_i              synchronous active-low reset
//   start_i            pipeline run enable
//   id_rs1_i/id_rs2_i  source register indices of the instruction in ID
//   id_uses_rs2_i      ID instruction reads rs2
//   ex_mem_i           Mem field of the EX instruction (01 load, 10 store)
//   ex_rd_i            destination register index of the EX instruction
//   id_branch_taken_i  branch resolved taken in ID
//   mem_op_i           Mem field of the MEM instruction
//   mem_ack_i          data memory completes the current access
//   pc_we_o            PC write enable
//   ifid_we_o          IF/ID write enable
//   ifid_flush_o       load a NOP into IF/ID
//   idex_bubble_o      zero the ID/EX control fields
//   stall_all_o        hold ID/EX, EX/MEM and MEM/WB
//   mem_req_o          data-memory request
//   stall_cnt_o        stall-cycle count (feature macro only)
//   flush_cnt_o        flush count (feature macro only)
//   state_dbg_o        current FSM state (0 IDLE, 1 RUN, 2 MEM_WAIT)
//
// Handshake: mem_req_o is held high from the first request cycle through the
// cycle in which mem_ack_i is sampled high; the access completes in that ack
// cycle and the request drops afterwards unless a new access is presented.
// -----------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [4:0]       id_rs1_i,
    input  logic [4:0]       id_rs2_i,
    input  logic             id_uses_rs2_i,
    input  logic [1:0]       ex_mem_i,
    input  logic [4:0]       ex_rd_i,
    input  logic             id_branch_taken_i,
    input  logic [1:0]       mem_op_i,
    input  logic             mem_ack_i,
    output logic             pc_we_o,
    output logic             ifid_we_o,
    output logic             ifid_flush_o,
    output logic             idex_bubble_o,
    output logic             stall_all_o,
    output logic             mem_req_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o,
    output logic [1:0]       state_dbg_o
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_MEM_WAIT = 2'd2
    } state_e;

    state_e state_q;
    state_e state_d;

    logic load_use;
    logic mem_access;

    // A load in EX whose rd feeds the ID instruction cannot be forwarded in
    // time; x0 never creates a dependency.
    assign load_use = (ex_mem_i == 2'b01) && (ex_rd_i != 5'd0) &&
                      ((ex_rd_i == id_rs1_i) ||
                       (id_uses_rs2_i && (ex_rd_i == id_rs2_i)));

    assign mem_access = (mem_op_i != 2'b00);

    // Next state and Mealy outputs. Priority in RUN:
    // memory stall > load-use stall > branch flush.
    always_comb begin
        state_d       = state_q;
        pc_we_o       = 1'b0;
        ifid_we_o     = 1'b0;
        ifid_flush_o  = 1'b0;
        idex_bubble_o = 1'b0;
        stall_all_o   = 1'b0;
        mem_req_o     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_RUN;
                end
            end

            ST_RUN: begin
                if (mem_access && !mem_ack_i) begin
                    // An unacknowledged access freezes everything, even when
                    // start_i has dropped: the access must finish first.
                    mem_req_o   = 1'b1;
                    stall_all_o = 1'b1;
                    state_d     = ST_MEM_WAIT;
                end else if (!start_i) begin
                    // An access acknowledged in this very cycle still needs
                    // its request; everything else is quiet.
                    mem_req_o = mem_access;
                    state_d   = ST_IDLE;
                end else begin
                    mem_req_o = mem_access;
                    pc_we_o   = 1'b1;
                    ifid_we_o = 1'b1;
                    if (load_use) begin
                        // The load moves to MEM next cycle, so this bubble
                        // is naturally a single cycle. A coincident taken
                        // branch is held and re-evaluated next cycle.
                        pc_we_o       = 1'b0;
                        ifid_we_o     = 1'b0;
                        idex_bubble_o = 1'b1;
                    end else if (id_branch_taken_i) begin
                        ifid_flush_o = 1'b1;
                    end
                end
            end

            ST_MEM_WAIT: begin
                mem_req_o = 1'b1;
                if (mem_ack_i) begin
                    // The pipeline advances in the ack cycle itself.
                    pc_we_o   = 1'b1;
                    ifid_we_o = 1'b1;
                    state_d   = start_i ? ST_RUN : ST_IDLE;
                end else begin
                    stall_all_o = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_dbg_o = state_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;
    logic             stall_inc;
    logic             flush_inc;

    // IDLE also has pc_we_o low but is not a stall.
    assign stall_inc = ((state_q == ST_RUN) || (state_q == ST_MEM_WAIT)) &&
                       !pc_we_o;
    assign flush_inc = ifid_flush_o;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            // Saturate at all-ones instead of wrapping.
            if (stall_inc && !(&stall_cnt_q)) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
            if (flush_inc && !(&flush_cnt_q)) begin
                flush_cnt_q <= flush_cnt_q + 1'b1;
            end
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
`else
    assign stall_cnt_o = '0;
    assign flush_cnt_o = '0;
`endif

endmodule
